ts_cursor_window: RTL and testbench

//  Text-screen cursor engine, successor to the fixed-screen cursor. Tracks cursor x/y
//  for the text sequencer; supports 1x/2x glyph sizes and four write orientations.

---
 rtl/ts_cursor_window.sv | 279 +++++++++++++++++++++++++++
 tb/tb_ts_cursor_window.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_cursor_window.sv
// ---------------------------------------------------------------------------
// ts_cursor_window
//   Text-screen cursor engine. Tracks the cursor column/row for the text
//   sequencer with 1x/2x glyph sizes and four write orientations, a
//   programmable scroll window, reverse line feed, CR/HOME/TAB and a
//   save/restore stack. Every command takes effect on the next clock edge.
//   When a line feed runs off the window, a one-cycle scroll request is
//   raised for the scroll engine.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   command[3:0]      0 NOP,1 SET,2 UP,3 DOWN,4 LEFT,5 RIGHT,6 NEXT_CHAR,
//                     7 LF,8 RLF,9 TAB,10 SAVE,11 RESTORE,12 HOME,13 CR
//   horz_size         1 = double-width glyphs (w=2)
//   vert_size         1 = double-height glyphs (h=2)
//   orientation[1:0]  0 right, 1 left, 2 down, 3 up
//   in_x, in_y        SET target
//   win_top/bottom    scroll window rows (inclusive)
//   x, y              cursor position
//   scroll            one-cycle scroll request
//   scroll_down       with scroll: 0 content up (LF), 1 content down (RLF)
//   scroll_lines      with scroll: rows to scroll (= h)
//   stack_empty/full  save-stack status
//   error             one-cycle pulse: SAVE when full / RESTORE when empty
// ---------------------------------------------------------------------------
module ts_cursor_window #(
    parameter int COLUMNS    = 80,
    parameter int ROWS       = 51,
    parameter int XW         = 7,
    parameter int YW         = 6,
    parameter int SAVE_DEPTH = 4,
    parameter int TAB_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    command,
    input  logic          horz_size,
    input  logic          vert_size,
    input  logic [1:0]    orientation,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    input  logic [YW-1:0] win_top,
    input  logic [YW-1:0] win_bottom,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          scroll,
    output logic          scroll_down,
    output logic [1:0]    scroll_lines,
    output logic          stack_empty,
    output logic          stack_full,
    output logic          error
);

    typedef enum logic [3:0] {
        CMD_NOP       = 4'd0,
        CMD_SET       = 4'd1,
        CMD_UP        = 4'd2,
        CMD_DOWN      = 4'd3,
        CMD_LEFT      = 4'd4,
        CMD_RIGHT     = 4'd5,
        CMD_NEXT_CHAR = 4'd6,
        CMD_LF        = 4'd7,
        CMD_RLF       = 4'd8,
        CMD_TAB       = 4'd9,
        CMD_SAVE      = 4'd10,
        CMD_RESTORE   = 4'd11,
        CMD_HOME      = 4'd12,
        CMD_CR        = 4'd13
    } cmd_e;

    typedef enum logic [1:0] {
        ORI_RIGHT = 2'd0,
        ORI_LEFT  = 2'd1,
        ORI_DOWN  = 2'd2,
        ORI_UP    = 2'd3
    } ori_e;

    // One extra bit on x/y arithmetic so overflow past the screen edge is
    // visible to the comparisons instead of wrapping.
    typedef logic [XW:0] xw_t;
    typedef logic [YW:0] yw_t;

    localparam int CW = $clog2(SAVE_DEPTH + 1);
    localparam int AW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] idx_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } pos_t;

    localparam xw_t  LAST_COL   = xw_t'(COLUMNS - 1);
    localparam yw_t  LAST_ROW   = yw_t'(ROWS - 1);
    localparam xw_t  TAB_W      = xw_t'(TAB_WIDTH);
    localparam xw_t  X1         = xw_t'(1);
    localparam yw_t  Y1         = yw_t'(1);
    localparam cnt_t C1         = cnt_t'(1);
    localparam cnt_t FULL_COUNT = cnt_t'(SAVE_DEPTH);

    // Stack state
    pos_t stack_mem [SAVE_DEPTH];
    cnt_t count;
    idx_t push_idx, top_idx;
    pos_t top;

    // Derived geometry
    xw_t  xe, we, we_m1, line_start_left, x_fwd, tab_next, tab_x;
    yw_t  ye, he, he_m1, win_t, win_b, bottom_start;
    logic win_ok, fits_right, fits_down, can_up;

    // Line-feed result for the current orientation
    xw_t  lf_x;
    yw_t  lf_y;
    logic lf_scroll;

    // Next-state
    xw_t        x_n;
    yw_t        y_n;
    logic       scroll_n, down_n, err_n, push, pop, lf_take;
    logic [1:0] lines_n;

    assign xe    = {1'b0, x};
    assign ye    = {1'b0, y};
    assign we    = horz_size ? xw_t'(2) : xw_t'(1);
    assign we_m1 = horz_size ? xw_t'(1) : xw_t'(0);
    assign he    = vert_size ? yw_t'(2) : yw_t'(1);
    assign he_m1 = vert_size ? yw_t'(1) : yw_t'(0);

    // A malformed window, or a cursor sitting outside it, falls back to
    // the full screen.
    assign win_ok = (win_top <= win_bottom) && ({1'b0, win_bottom} <= LAST_ROW) &&
                    (y >= win_top) && (y <= win_bottom);
    assign win_t  = win_ok ? {1'b0, win_top}    : '0;
    assign win_b  = win_ok ? {1'b0, win_bottom} : LAST_ROW;

    // x+2w-1 <= LAST_COL is written as x + w + (w-1) to stay unsigned.
    assign fits_right      = (xe + we + we_m1) <= LAST_COL;
    assign fits_down       = (ye + he + he_m1) <= win_b;
    assign can_up          = ye >= (win_t + he);
    assign line_start_left = LAST_COL - we_m1;
    assign bottom_start    = (win_b >= he_m1) ? (win_b - he_m1) : '0;
    assign x_fwd           = fits_right ? (xe + we) : '0;

    assign tab_next = xe + (TAB_W - (xe % TAB_W));
    assign tab_x    = (tab_next > line_start_left) ? line_start_left : tab_next;

    assign push_idx    = idx_t'(count);
    assign top_idx     = idx_t'(count - C1);
    assign top         = stack_mem[top_idx];
    assign stack_empty = (count == '0);
    assign stack_full  = (count == FULL_COUNT);

    always_comb begin
        lf_x      = xe;
        lf_y      = ye;
        lf_scroll = 1'b0;
        case (orientation)
            ORI_RIGHT, ORI_LEFT: begin
                lf_x = (orientation == ORI_LEFT) ? line_start_left : '0;
                if (fits_down) begin
                    lf_y = ye + he;
                end else begin
                    lf_y      = bottom_start;
                    lf_scroll = 1'b1;
                end
            end
            ORI_DOWN: begin
                lf_y = win_t;
                lf_x = x_fwd;
            end
            default: begin
                lf_y = bottom_start;
                lf_x = x_fwd;
            end
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        x_n      = xe;
        y_n      = ye;
        scroll_n = 1'b0;
        down_n   = 1'b0;
        err_n    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        lf_take  = 1'b0;
        case (command)
            CMD_SET: begin
                x_n = ({1'b0, in_x} > LAST_COL) ? LAST_COL : {1'b0, in_x};
                y_n = ({1'b0, in_y} > LAST_ROW) ? LAST_ROW : {1'b0, in_y};
            end
            CMD_UP:    if (ye != '0)      y_n = ye - Y1;
            CMD_DOWN:  if (ye < LAST_ROW) y_n = ye + Y1;
            CMD_LEFT:  if (xe != '0)      x_n = xe - X1;
            CMD_RIGHT: if (xe < LAST_COL) x_n = xe + X1;
            CMD_NEXT_CHAR: begin
                case (orientation)
                    ORI_RIGHT: if (fits_right) x_n = xe + we; else lf_take = 1'b1;
                    ORI_LEFT:  if (xe >= we)   x_n = xe - we; else lf_take = 1'b1;
                    ORI_DOWN:  if (fits_down)  y_n = ye + he; else lf_take = 1'b1;
                    default:   if (can_up)     y_n = ye - he; else lf_take = 1'b1;
                endcase
            end
            CMD_LF: lf_take = 1'b1;
            CMD_RLF: begin
                if (can_up) begin
                    y_n = ye - he;
                end else begin
                    y_n      = win_t;
                    scroll_n = 1'b1;
                    down_n   = 1'b1;
                end
            end
            CMD_TAB: x_n = tab_x;
            CMD_SAVE: begin
                if (stack_full) err_n = 1'b1;
                else            push  = 1'b1;
            end
            CMD_RESTORE: begin
                if (stack_empty) begin
                    err_n = 1'b1;
                end else begin
                    pop = 1'b1;
                    x_n = {1'b0, top.x};
                    y_n = {1'b0, top.y};
                end
            end
            CMD_HOME: begin
                x_n = '0;
                y_n = win_t;
            end
            CMD_CR: x_n = (orientation == ORI_LEFT) ? line_start_left : '0;
            default: ;
        endcase
        if (lf_take) begin
            x_n      = lf_x;
            y_n      = lf_y;
            scroll_n = lf_scroll;
        end
        lines_n = scroll_n ? (vert_size ? 2'd2 : 2'd1) : 2'd0;
    end

    // Results are always clamped on screen, so the guard bits are zero here.
    logic unused_ok;
    assign unused_ok = &{1'b1, x_n[XW], y_n[YW]};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values together.
        if (reset) begin
            x            <= '0;
            y            <= '0;
            scroll       <= 1'b0;
            scroll_down  <= 1'b0;
            scroll_lines <= 2'd0;
            error        <= 1'b0;
            count        <= '0;
        end else begin
            x            <= x_n[XW-1:0];
            y            <= y_n[YW-1:0];
            scroll       <= scroll_n;
            scroll_down  <= down_n;
            scroll_lines <= lines_n;
            error        <= err_n;
            if (push) count <= count + C1;
            if (pop)  count <= count - C1;
        end
    end

    // NOTE: stack storage is not reset; only the count is, and entries at
    // or above the count are never read.
    always_ff @(posedge clk) begin
        if (!reset && push) stack_mem[push_idx] <= '{x: x, y: y};
    end

endmodule

// File: tb/tb_ts_cursor_window.sv
module tb_ts_cursor_window;

    localparam int XW = 7;
    localparam int YW = 6;

    localparam int C_NOP = 0, C_SET = 1, C_UP = 2, C_DOWN = 3, C_LEFT = 4,
                   C_RIGHT = 5, C_NEXT = 6, C_LF = 7, C_RLF = 8, C_TAB = 9,
                   C_SAVE = 10, C_RESTORE = 11, C_HOME = 12, C_CR = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    command = '0;
    logic          horz_size = 1'b0;
    logic          vert_size = 1'b0;
    logic [1:0]    orientation = '0;
    logic [XW-1:0] in_x = '0;
    logic [YW-1:0] in_y = '0;
    logic [YW-1:0] win_top = '0;
    logic [YW-1:0] win_bottom = 6'd50;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          scroll, scroll_down, stack_empty, stack_full, error;
    logic [1:0]    scroll_lines;

    always #5 clk = ~clk;

    ts_cursor_window dut (
        .clk         (clk),
        .reset       (reset),
        .command     (command),
        .horz_size   (horz_size),
        .vert_size   (vert_size),
        .orientation (orientation),
        .in_x        (in_x),
        .in_y        (in_y),
        .win_top     (win_top),
        .win_bottom  (win_bottom),
        .x           (x),
        .y           (y),
        .scroll      (scroll),
        .scroll_down (scroll_down),
        .scroll_lines(scroll_lines),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .error       (error)
    );

    typedef struct {
        logic          rst;
        logic [3:0]    cmd;
        logic          hs, vs;
        logic [1:0]    ori;
        logic [XW-1:0] ix;
        logic [YW-1:0] iy;
        logic [YW-1:0] wt, wb;
        int            ex, ey;
        logic          es, ed;
        int            el;
        logic          ee, emp, ful;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    // Current mode and expected stack flags used when building records.
    logic       m_hs = 0, m_vs = 0;
    logic [1:0] m_ori = 0;
    int         m_wt = 0, m_wb = 50;
    logic       f_emp = 1, f_ful = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void mode(input logic hs, input logic vs, input int ori,
                                 input int wt, input int wb);
        m_hs = hs; m_vs = vs; m_ori = 2'(ori); m_wt = wt; m_wb = wb;
    endfunction

    function automatic void flags(input logic emp, input logic ful);
        f_emp = emp; f_ful = ful;
    endfunction

    function automatic vec_t mk(input logic rst, input int cmd, input int ix, input int iy,
                                input int ex, input int ey, input logic es, input logic ed,
                                input int el, input logic ee);
        vec_t v;
        v.rst = rst;  v.cmd = 4'(cmd);
        v.hs  = m_hs; v.vs  = m_vs; v.ori = m_ori;
        v.ix  = XW'(ix); v.iy = YW'(iy);
        v.wt  = YW'(m_wt); v.wb = YW'(m_wb);
        v.ex  = ex; v.ey = ey; v.es = es; v.ed = ed; v.el = el; v.ee = ee;
        v.emp = f_emp; v.ful = f_ful;
        return v;
    endfunction

    function automatic void add(input int cmd, input int ix, input int iy, input int ex,
                                input int ey, input logic es, input logic ed, input int el,
                                input logic ee);
        tbl.push_back(mk(1'b0, cmd, ix, iy, ex, ey, es, ed, el, ee));
    endfunction

    function automatic void pos(input int cmd, input int ix, input int iy, input int ex, input int ey);
        add(cmd, ix, iy, ex, ey, 0, 0, 0, 0);
    endfunction

    // Drive one record at the falling edge, queue its expectation, then
    // compare just after the rising edge that applies it.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        reset       = v.rst;
        command     = v.cmd;
        horz_size   = v.hs;
        vert_size   = v.vs;
        orientation = v.ori;
        in_x        = v.ix;
        in_y        = v.iy;
        win_top     = v.wt;
        win_bottom  = v.wb;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".x"},     32'(x),           32'(e.ex));
            check({tag, ".y"},     32'(y),           32'(e.ey));
            check({tag, ".scroll"},32'(scroll),      32'(e.es));
            check({tag, ".error"}, 32'(error),       32'(e.ee));
            check({tag, ".empty"}, 32'(stack_empty), 32'(e.emp));
            check({tag, ".full"},  32'(stack_full),  32'(e.ful));
            if (e.es || e.rst) begin
                check({tag, ".down"},  32'(scroll_down),  32'(e.ed));
                check({tag, ".lines"}, 32'(scroll_lines), 32'(e.el));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- table build ----------------
        mode(0, 0, 0, 0, 50); flags(1, 0);
        tbl.push_back(mk(1'b1, C_NOP, 0, 0, 0, 0, 0, 0, 0, 0));

        // 80 NEXT_CHAR right at 1x: wraps to the next line on the 80th
        for (int k = 1; k <= 80; k++)
            pos(C_NEXT, 0, 0, (k < 80) ? k : 0, (k < 80) ? 0 : 1);

        // LF at window bottom with double height scrolls two rows
        mode(0, 0, 0, 10, 20); pos(C_SET, 0, 20, 0, 20);
        mode(0, 1, 0, 10, 20); add(C_LF, 0, 0, 0, 19, 1, 0, 2, 0);
        pos(C_NOP, 0, 0, 0, 19);

        // RLF at window top scrolls content down
        mode(0, 0, 0, 10, 20); pos(C_SET, 5, 10, 5, 10);
        add(C_RLF, 0, 0, 5, 10, 1, 1, 1, 0);
        pos(C_NOP, 0, 0, 5, 10);
        // inverted window -> full screen
        mode(0, 0, 0, 30, 20); pos(C_RLF, 0, 0, 5, 9);
        pos(C_SET, 5, 0, 5, 0);
        add(C_RLF, 0, 0, 5, 0, 1, 1, 1, 0);
        pos(C_SET, 0, 50, 0, 50);
        add(C_LF, 0, 0, 0, 50, 1, 0, 1, 0);
        add(C_LF, 0, 0, 0, 50, 1, 0, 1, 0);
        // bottom past last row, then cursor outside window -> full screen
        mode(0, 0, 0, 10, 60); add(C_LF, 0, 0, 0, 50, 1, 0, 1, 0);
        mode(0, 0, 0, 10, 20); add(C_LF, 0, 0, 0, 50, 1, 0, 1, 0);
        mode(0, 1, 0, 10, 20); add(C_LF, 0, 0, 0, 49, 1, 0, 2, 0);
        mode(0, 0, 0, 10, 20); pos(C_SET, 3, 12, 3, 12);
        pos(C_LF, 0, 0, 0, 13);
        pos(C_HOME, 0, 0, 0, 10);
        pos(C_SET, 40, 30, 40, 30);
        pos(C_HOME, 0, 0, 0, 0);

        // double width wrap right, then orientation left wrap
        mode(1, 0, 0, 0, 50); pos(C_SET, 78, 0, 78, 0);
        pos(C_NEXT, 0, 0, 0, 1);
        pos(C_SET, 1, 1, 1, 1);
        mode(1, 0, 1, 0, 50); pos(C_NEXT, 0, 0, 78, 2);
        pos(C_NEXT, 0, 0, 76, 2);
        // orientation down / up
        mode(0, 1, 2, 0, 50); pos(C_SET, 10, 49, 10, 49);
        pos(C_NEXT, 0, 0, 11, 0);
        pos(C_NEXT, 0, 0, 11, 2);
        mode(0, 0, 3, 0, 50); pos(C_SET, 79, 0, 79, 0);
        pos(C_NEXT, 0, 0, 0, 50);
        pos(C_NEXT, 0, 0, 0, 49);
        mode(1, 0, 2, 0, 50); pos(C_SET, 78, 5, 78, 5);
        pos(C_LF, 0, 0, 0, 0);
        pos(C_LF, 0, 0, 2, 0);
        mode(0, 1, 3, 10, 20); pos(C_SET, 4, 12, 4, 12);
        pos(C_NEXT, 0, 0, 4, 10);
        pos(C_NEXT, 0, 0, 5, 19);

        // TAB and CR
        mode(0, 0, 0, 0, 50); pos(C_SET, 77, 3, 77, 3);
        pos(C_TAB, 0, 0, 79, 3);
        pos(C_SET, 3, 3, 3, 3);
        pos(C_TAB, 0, 0, 8, 3);
        pos(C_TAB, 0, 0, 16, 3);
        mode(1, 0, 0, 0, 50); pos(C_SET, 72, 3, 72, 3);
        pos(C_TAB, 0, 0, 78, 3);
        pos(C_SET, 0, 3, 0, 3);
        pos(C_TAB, 0, 0, 8, 3);
        mode(1, 0, 1, 0, 50); pos(C_CR, 0, 0, 78, 3);
        mode(0, 0, 0, 0, 50); pos(C_CR, 0, 0, 0, 3);

        // clamping and undefined codes
        pos(C_SET, 127, 63, 79, 50);
        pos(C_RIGHT, 0, 0, 79, 50);
        pos(C_DOWN, 0, 0, 79, 50);
        pos(C_LEFT, 0, 0, 78, 50);
        pos(C_UP, 0, 0, 78, 49);
        pos(C_SET, 0, 0, 0, 0);
        pos(C_LEFT, 0, 0, 0, 0);
        pos(C_UP, 0, 0, 0, 0);
        pos(C_RIGHT, 0, 0, 1, 0);
        pos(C_DOWN, 0, 0, 1, 1);
        pos(14, 0, 0, 1, 1);
        pos(15, 0, 0, 1, 1);

        // save stack: four pushes, overflow, LIFO pops, underflow
        pos(C_SET, 1, 2, 1, 2);
        flags(0, 0); pos(C_SAVE, 0, 0, 1, 2);
        pos(C_SET, 3, 4, 3, 4);  pos(C_SAVE, 0, 0, 3, 4);
        pos(C_SET, 5, 6, 5, 6);  pos(C_SAVE, 0, 0, 5, 6);
        pos(C_SET, 7, 8, 7, 8);
        flags(0, 1); pos(C_SAVE, 0, 0, 7, 8);
        pos(C_SET, 9, 9, 9, 9);
        add(C_SAVE, 0, 0, 9, 9, 0, 0, 0, 1);
        flags(0, 0); pos(C_RESTORE, 0, 0, 7, 8);
        pos(C_RESTORE, 0, 0, 5, 6);
        pos(C_RESTORE, 0, 0, 3, 4);
        flags(1, 0); pos(C_RESTORE, 0, 0, 1, 2);
        add(C_RESTORE, 0, 0, 1, 2, 0, 0, 0, 1);
        pos(C_NOP, 0, 0, 1, 2);

        // ---------------- table apply ----------------
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // ---------------- hand-written: reset while the stack holds data ----
        mode(0, 0, 0, 0, 50); flags(1, 0);
        step("rs_set", mk(1'b0, C_SET, 20, 20, 20, 20, 0, 0, 0, 0));
        flags(0, 0);
        step("rs_save1", mk(1'b0, C_SAVE, 0, 0, 20, 20, 0, 0, 0, 0));
        step("rs_save2", mk(1'b0, C_SAVE, 0, 0, 20, 20, 0, 0, 0, 0));
        flags(1, 0);
        step("rs_hold_save", mk(1'b1, C_SAVE, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rs_hold_set",  mk(1'b1, C_SET, 9, 9, 0, 0, 0, 0, 0, 0));
        step("rs_restore_empty", mk(1'b0, C_RESTORE, 0, 0, 0, 0, 0, 0, 0, 1));
        flags(0, 0);
        step("rs_save_again", mk(1'b0, C_SAVE, 0, 0, 0, 0, 0, 0, 0, 0));
        flags(1, 0);
        step("rs_restore_again", mk(1'b0, C_RESTORE, 0, 0, 0, 0, 0, 0, 0, 0));

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
